// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Optional header byte per register is enabled by defining RF_DUMP_HEADER_EN.
package rf_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

`ifdef RF_DUMP_HEADER_EN
    localparam int BYTES_PER_REG = 5;
    localparam int CNT_W         = 3;
`else
    localparam int BYTES_PER_REG = 4;
    localparam int CNT_W         = 2;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(BYTES_PER_REG - 1);
    localparam logic [2:0]       HEADER_PREFIX = 3'b100;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks the register-file debug port and streams each register as bytes over valid/ready.
// Define RF_DUMP_HEADER_EN to prefix every register with a {3'b100, index} header byte.
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        done
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [31:0]       latch, latch_next;
    logic [4:0]        sel_next;
    logic              valid_next;
    logic [7:0]        byte_next;
    logic              busy_next;
    logic              done_next;
    logic [7:0]        first_byte;
    logic [7:0]        following_byte;

    // Data-byte index 0..3 maps to a word lane according to the send order.
    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
        lane = (MSB_FIRST != 0) ? (2'd3 - idx) : idx;
        case (lane)
            2'd0:    pick_byte = word[7:0];
            2'd1:    pick_byte = word[15:8];
            2'd2:    pick_byte = word[23:16];
            default: pick_byte = word[31:24];
        endcase
    endfunction

    // The first byte is built from live reg_data because the latch is only written on this edge.
    always_comb begin
`ifdef RF_DUMP_HEADER_EN
        first_byte     = {HEADER_PREFIX, reg_sel};
        following_byte = pick_byte(latch, cnt[1:0]);
`else
        first_byte     = pick_byte(reg_data, 2'd0);
        following_byte = pick_byte(latch, 2'(cnt + 1'b1));
`endif
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_next = latch;
        sel_next   = reg_sel;
        valid_next = tx_valid;
        byte_next  = tx_byte;
        busy_next  = busy;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                sel_next = 5'(FIRST_REG);
                if (start) begin
                    state_next = LOAD;
                    busy_next  = 1'b1;
                end
            end
            LOAD: begin
                latch_next = reg_data;
                cnt_next   = '0;
                valid_next = 1'b1;
                byte_next  = first_byte;
                state_next = SEND;
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (cnt == LAST_CNT) begin
                        cnt_next   = '0;
                        valid_next = 1'b0;
                        if (reg_sel == 5'(LAST_REG)) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            sel_next   = reg_sel + 5'd1;
                            state_next = LOAD;
                        end
                    end else begin
                        cnt_next  = CNT_W'(cnt + 1'b1);
                        byte_next = following_byte;
                    end
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            latch    <= '0;
            reg_sel  <= 5'(FIRST_REG);
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            latch    <= latch_next;
            reg_sel  <= sel_next;
            tx_valid <= valid_next;
            tx_byte  <= byte_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a full LSB-first dump instance and a single-register MSB-first instance.
// Expectations follow RF_DUMP_HEADER_EN when the bench is built with it defined.
module tb_rf_dump_reader;

`ifdef RF_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BPR   = 4 + HDR;
    localparam int TOTAL = 32 * BPR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] rf [32];

    logic        start_f, ready_f, valid_f, busy_f, done_f;
    logic [4:0]  sel_f;
    logic [31:0] data_f;
    logic [7:0]  byte_f;

    logic        start_s, ready_s, valid_s, busy_s, done_s;
    logic [4:0]  sel_s;
    logic [31:0] data_s;
    logic [7:0]  byte_s;

    assign data_f = rf[sel_f];
    assign data_s = rf[sel_s];

    rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .MSB_FIRST(0)) dut_full (
        .clk(clk), .rst(rst), .start(start_f), .reg_sel(sel_f), .reg_data(data_f),
        .tx_valid(valid_f), .tx_ready(ready_f), .tx_byte(byte_f), .busy(busy_f), .done(done_f)
    );

    rf_dump_reader #(.FIRST_REG(7), .LAST_REG(7), .MSB_FIRST(1)) dut_single (
        .clk(clk), .rst(rst), .start(start_s), .reg_sel(sel_s), .reg_data(data_s),
        .tx_valid(valid_s), .tx_ready(ready_s), .tx_byte(byte_s), .busy(busy_s), .done(done_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s_f, input logic r_f, input logic s_s, input logic r_s);
        start_f = s_f;
        ready_f = r_f;
        start_s = s_s;
        ready_s = r_s;
    endtask

    task automatic stepClock();
        @(negedge clk);
    endtask

    // Byte k of a register's stream, from the bench's own copy of the register file.
    function automatic logic [7:0] exp_byte(input int reg_idx, input int k, input bit msb_first);
        logic [31:0] word;
        int d;
        word = rf[reg_idx];
        d = k - HDR;
        if (d < 0) return {3'b100, 5'(reg_idx)};
        if (msb_first) d = 3 - d;
        return word[8*d +: 8];
    endfunction

    initial begin
        int k;
        int done_cnt;
        bit found;

        for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset and idle behaviour
        stepClock();
        stepClock();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            stepClock();
            checkOutput("idle tx_valid", valid_f, 0);
            checkOutput("idle busy", busy_f, 0);
            checkOutput("idle done", done_f, 0);
            checkOutput("idle reg_sel", sel_f, 0);
        end
        checkOutput("idle single reg_sel", sel_s, 7);

        // Single register, MSB first, with a stray start while busy
        rf[7] = 32'h1234_5678;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        stepClock();
        start_s = 1'b0;
        checkOutput("single busy in LOAD", busy_s, 1);
        checkOutput("single valid in LOAD", valid_s, 0);
        checkOutput("single reg_sel", sel_s, 7);
        for (int b = 0; b < BPR; b++) begin
            stepClock();
            checkOutput($sformatf("single valid %0d", b), valid_s, 1);
            checkOutput($sformatf("single byte %0d", b), byte_s, exp_byte(7, b, 1'b1));
            start_s = (b == 1);
        end
        start_s = 1'b0;
        stepClock();
        checkOutput("single done pulse", done_s, 1);
        checkOutput("single valid after last", valid_s, 0);
        checkOutput("single busy in DONE", busy_s, 1);
        stepClock();
        checkOutput("single done cleared", done_s, 0);
        checkOutput("single busy cleared", busy_s, 0);
        stepClock();
        checkOutput("single start while busy ignored", busy_s, 0);

        // Backpressure: sink ready one cycle in three
        rf[7] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepClock();
        start_s = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && k < BPR; c++) begin
            stepClock();
            checkOutput($sformatf("bp valid held c%0d", c), valid_s, 1);
            checkOutput($sformatf("bp byte c%0d", c), byte_s, exp_byte(7, k, 1'b1));
            ready_s = ((c % 3) == 2);
            if (ready_s) k++;
        end
        checkOutput("bp bytes accepted", k, BPR);
        stepClock();
        ready_s = 1'b0;
        checkOutput("bp done pulse", done_s, 1);
        stepClock();
        checkOutput("bp busy cleared", busy_s, 0);

        // Full dump, LSB first, registers 0..31
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        start_f = 1'b0;
        k = 0;
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            stepClock();
            if (done_f) done_cnt++;
            if (valid_f && ready_f) begin
                checkOutput($sformatf("full byte %0d", k), byte_f, exp_byte(k / BPR, k % BPR, 1'b0));
                checkOutput($sformatf("full reg_sel %0d", k), sel_f, k / BPR);
                k++;
            end
            if (k == TOTAL && !busy_f) break;
        end
        checkOutput("full byte count", k, TOTAL);
        checkOutput("full done count", done_cnt, 1);
        checkOutput("full busy cleared", busy_f, 0);

        // Reset during the second byte of register 3
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        start_f = 1'b0;
        k = 0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            stepClock();
            if (k == 3 * BPR + 1 && valid_f) begin
                found = 1'b1;
                rst = 1'b1;
                break;
            end
            if (valid_f && ready_f) k++;
        end
        checkOutput("abort point reached", found, 1);
        stepClock();
        rst = 1'b0;
        checkOutput("abort tx_valid", valid_f, 0);
        checkOutput("abort busy", busy_f, 0);
        checkOutput("abort reg_sel", sel_f, 0);
        checkOutput("abort done", done_f, 0);
        stepClock();
        checkOutput("abort stays idle", busy_f, 0);
        start_f = 1'b1;
        stepClock();
        start_f = 1'b0;
        checkOutput("restart busy", busy_f, 1);
        checkOutput("restart reg_sel", sel_f, 0);
        stepClock();
        checkOutput("restart valid", valid_f, 1);
        checkOutput("restart first byte", byte_f, exp_byte(0, 0, 1'b0));

        rst = 1'b1;
        stepClock();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
